// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and receiver state encodings.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_BREAK = ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level; resets to 1 so an idle serial line reads idle.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: validates the start bit at half a bit, samples data and stop bits at bit centres.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (data_in),
    .sync_out (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      data_q <= data_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames, glitch, framing error, mid-frame reset, latency, random traffic.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int C16 = 16;
  localparam int C4  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in, data_in4;
  logic [7:0] data_out, data_out4;
  logic       rx_done, rx_busy, frame_err;
  logic       rx_done4, rx_busy4, frame_err4;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(C16)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
    .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  uart_receiver #(.CLKS_PER_BIT(C4)) u_dut4 (
    .clk(clk), .rst(rst), .data_in(data_in4), .data_out(data_out4),
    .rx_done(rx_done4), .rx_busy(rx_busy4), .frame_err(frame_err4)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         done4_cnt = 0;
  logic [7:0] last4 = 8'h00;
  bit         gap_en = 1'b0;
  bit         seen_busy = 1'b0;
  int         low_run = 0;
  int         max_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_line(input bit lane4, input logic v, input int n);
    if (lane4) data_in4 = v;
    else       data_in  = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit lane4, input logic [7:0] b, input logic stop);
    int c;
    c = lane4 ? C4 : C16;
    drive_line(lane4, 1'b0, c);
    for (int i = 0; i < 8; i++) drive_line(lane4, b[i], c);
    drive_line(lane4, stop, c);
  endtask

  task automatic measure_lat(input bit lane4, input logic [7:0] b, output int n);
    int limit;
    limit = 12 * (lane4 ? C4 : C16) + 20;
    n = 0;
    fork
      send_frame(lane4, b, 1'b1);
      begin
        do begin
          @(negedge clk);
          n++;
        end while (!(lane4 ? rx_done4 : rx_done) && n < limit);
      end
    join
  endtask

  // Observe strobes and the idle gaps between busy periods.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done) begin
        obs_q.push_back(data_out);
        done_cnt++;
      end
      if (frame_err) err_cnt++;
      if (rx_done || frame_err) check("excl", {31'b0, rx_done & frame_err}, 32'd0);
      if (rx_done4) begin
        done4_cnt++;
        last4 = data_out4;
      end
      if (gap_en) begin
        if (rx_busy) begin
          if (seen_busy && low_run > max_gap) max_gap = low_run;
          seen_busy = 1'b1;
          low_run   = 0;
        end else begin
          low_run++;
        end
      end
    end
  end

  initial begin
    int         n, d0, e0, exp_err, cyc;
    bit         seen_hi;
    logic [7:0] prev, b;
    logic [7:0] tbl[4];
    logic [7:0] f96;
    bit         bad;

    rst = 1'b1;
    data_in = 1'b1;
    data_in4 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'b0, data_out}, 32'h00);
    check("rst_done", {31'b0, rx_done}, 32'd0);
    check("rst_busy", {31'b0, rx_busy}, 32'd0);
    check("rst_ferr", {31'b0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame 0xCF.
    obs_q.delete();
    send_frame(1'b0, 8'hCF, 1'b1);
    drive_line(1'b0, 1'b1, 2 * C16);
    check("cf_count", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) check("cf_data", {24'b0, obs_q[0]}, 32'hCF);
    check("cf_ferr", err_cnt, 32'd0);

    // Four frames back to back with no idle gap.
    tbl[0] = 8'h00; tbl[1] = 8'hFF; tbl[2] = 8'hA5; tbl[3] = 8'h5A;
    obs_q.delete();
    seen_busy = 1'b0; low_run = 0; max_gap = 0; gap_en = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(1'b0, tbl[i], 1'b1);
    drive_line(1'b0, 1'b1, 2 * C16);
    gap_en = 1'b0;
    check("b2b_count", obs_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs_q.size()) check("b2b_data", {24'b0, obs_q[i]}, {24'b0, tbl[i]});
    // Stop is sampled mid-bit, so the line idles in IDLE for half a bit before the next start.
    check("b2b_gap", {31'b0, (max_gap <= C16 / 2 + 1)}, 32'd1);

    // Three-cycle low glitch on an idle line.
    d0 = done_cnt; e0 = err_cnt; prev = data_out;
    data_in = 1'b0;
    cyc = 0; seen_hi = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) data_in = 1'b1;
      if (rx_busy) seen_hi = 1'b1;
    end while (!(seen_hi && !rx_busy) && cyc < 4 * C16);
    check("glitch_busy_seen", {31'b0, seen_hi}, 32'd1);
    check("glitch_release", {31'b0, (cyc <= C16 / 2 + 3)}, 32'd1);
    drive_line(1'b0, 1'b1, C16);
    check("glitch_done", done_cnt, d0);
    check("glitch_ferr", err_cnt, e0);
    check("glitch_data", {24'b0, data_out}, {24'b0, prev});

    // Framing error followed by a held-low line.
    d0 = done_cnt; e0 = err_cnt; prev = data_out;
    send_frame(1'b0, 8'h3C, 1'b0);
    drive_line(1'b0, 1'b0, 3 * C16);
    check("ferr_busy_low", {31'b0, rx_busy}, 32'd1);
    check("ferr_count", err_cnt, e0 + 1);
    check("ferr_no_done", done_cnt, d0);
    check("ferr_data_kept", {24'b0, data_out}, {24'b0, prev});
    drive_line(1'b0, 1'b1, 4);
    check("ferr_idle", {31'b0, rx_busy}, 32'd0);
    drive_line(1'b0, 1'b1, 2 * C16);
    check("ferr_no_retrigger", err_cnt, e0 + 1);

    // Reset during data bit 4 of 0x96.
    f96 = 8'h96;
    drive_line(1'b0, 1'b0, C16);
    for (int i = 0; i < 4; i++) drive_line(1'b0, f96[i], C16);
    data_in = f96[4];
    repeat (C16 / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_data", {24'b0, data_out}, 32'h00);
    check("mrst_busy", {31'b0, rx_busy}, 32'd0);
    check("mrst_done", {31'b0, rx_done}, 32'd0);
    check("mrst_ferr", {31'b0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (C16 - C16 / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_line(1'b0, f96[i], C16);
    drive_line(1'b0, 1'b1, 13 * C16);
    obs_q.delete();
    send_frame(1'b0, 8'h69, 1'b1);
    drive_line(1'b0, 1'b1, 2 * C16);
    check("mrst_count", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) check("mrst_frame", {24'b0, obs_q[0]}, 32'h69);
    check("mrst_data_out", {24'b0, data_out}, 32'h69);

    // Latency from the first edge that sees the start bit.
    measure_lat(1'b0, 8'hB3, n);
    $display("latency C=16 cycles=%0d", n);
    check("lat16", {31'b0, (n >= 3 + C16/2 + 9*C16 - 1 && n <= 3 + C16/2 + 9*C16 + 1)}, 32'd1);
    drive_line(1'b0, 1'b1, 2 * C16);
    measure_lat(1'b1, 8'h4E, n);
    $display("latency C=4 cycles=%0d", n);
    check("lat4", {31'b0, (n >= 3 + C4/2 + 9*C4 - 1 && n <= 3 + C4/2 + 9*C4 + 1)}, 32'd1);
    drive_line(1'b1, 1'b1, 2 * C4);
    check("lat4_count", done4_cnt, 32'd1);
    check("lat4_data", {24'b0, last4}, 32'h4E);

    // Random frames, random gaps, occasional bad stop bit.
    obs_q.delete();
    exp_q.delete();
    exp_err = err_cnt;
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      send_frame(1'b0, b, !bad);
      if (bad) exp_err++;
      else     exp_q.push_back(b);
      drive_line(1'b0, 1'b1, bad ? $urandom_range(C16, 2 * C16) : $urandom_range(0, 2 * C16));
    end
    drive_line(1'b0, 1'b1, 2 * C16);
    check("rand_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check("rand_data", {24'b0, obs_q[i]}, {24'b0, exp_q[i]});
    check("rand_ferr", err_cnt, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
